pool_1: RTL and testbench



---
 rtl/pool_1_if.sv | 31 +++
 rtl/pool_1.sv | 198 +++++++++++++++++++
 tb/tb_pool_1.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_1_if.sv
// BRAM-side bus of the first pooling stage: read port of the conv-1 result
// BRAM and write port of the pool-1 result BRAM.
interface pool_1_if;
  logic [7:0]  conv_result_bram_douta;
  logic        conv_result_bram_ena;
  logic [14:0] conv_result_bram_addra;
  logic        pool_result_bram_ena;
  logic        pool_result_bram_wea;
  logic [11:0] pool_result_bram_addra;
  logic [7:0]  pool_result_bram_dina;

  modport master (
    input  conv_result_bram_douta,
    output conv_result_bram_ena,
    output conv_result_bram_addra,
    output pool_result_bram_ena,
    output pool_result_bram_wea,
    output pool_result_bram_addra,
    output pool_result_bram_dina
  );

  modport slave (
    output conv_result_bram_douta,
    input  conv_result_bram_ena,
    input  conv_result_bram_addra,
    input  pool_result_bram_ena,
    input  pool_result_bram_wea,
    input  pool_result_bram_addra,
    input  pool_result_bram_dina
  );
endinterface

// File: rtl/pool_1.sv
// LeNet pool-1: 2x2 stride-2 signed max pooling over DEPTH maps of
// IN_SIZE x IN_SIZE read from the conv-1 BRAM into the pool-1 BRAM.
module pool_1 #(
  parameter int READ_WAIT        = 3,
  parameter int CONV_RESULT_BASE = 0,
  parameter int POOL_RESULT_BASE = 0,
  parameter int DEPTH            = 20,
  parameter int IN_SIZE          = 24,
  parameter int OUT_SIZE         = 12
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pool_1_en,
  output logic     pool_1_finish,
  pool_1_if.master bram
);

  localparam int FW      = $clog2(DEPTH + 1);
  localparam int PW      = $clog2(OUT_SIZE + 1);
  localparam int WW      = $clog2(READ_WAIT + 1);
  localparam int MAP_IN  = IN_SIZE * IN_SIZE;
  localparam int MAP_OUT = OUT_SIZE * OUT_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_d;
  logic [FW-1:0]  f, f_d;
  logic [PW-1:0]  r, r_d, c, c_d;
  logic [1:0]     k, k_d;
  logic [WW-1:0]  wait_cnt, wait_d;
  logic [7:0]     max_val, max_d;
  logic           conv_ena, conv_ena_d;
  logic [14:0]    conv_addr, conv_addr_d;
  logic           pool_ena, pool_ena_d;
  logic           pool_wea, pool_wea_d;
  logic [11:0]    pool_addr, pool_addr_d;
  logic [7:0]     pool_dina, pool_dina_d;
  logic           finish, finish_d;
  int             rd_addr, wr_addr;

  // k[1] selects the window row (dy), k[0] the column (dx).
  always_comb begin
    rd_addr = CONV_RESULT_BASE + int'(f) * MAP_IN
            + (2 * int'(r) + int'(k[1])) * IN_SIZE
            + 2 * int'(c) + int'(k[0]);
    wr_addr = POOL_RESULT_BASE + int'(f) * MAP_OUT + int'(r) * OUT_SIZE + int'(c);
  end

  always_comb begin
    // NOTE: every next-state signal starts from its held value so that no
    // path through the case leaves one unassigned and infers a latch.
    state_d     = state;
    f_d         = f;
    r_d         = r;
    c_d         = c;
    k_d         = k;
    wait_d      = wait_cnt;
    max_d       = max_val;
    conv_ena_d  = conv_ena;
    conv_addr_d = conv_addr;
    pool_ena_d  = pool_ena;
    pool_wea_d  = pool_wea;
    pool_addr_d = pool_addr;
    pool_dina_d = pool_dina;
    finish_d    = finish;

    // Outside DONE a low enable freezes everything; the read port stays
    // enabled on the same address, so the pending BRAM data is still valid.
    case (state)
      IDLE: if (pool_1_en) begin
        f_d      = '0;
        r_d      = '0;
        c_d      = '0;
        k_d      = '0;
        wait_d   = '0;
        max_d    = '0;
        finish_d = 1'b0;
        state_d  = CHECK;
      end

      CHECK: if (pool_1_en) begin
        pool_ena_d = 1'b0;
        pool_wea_d = 1'b0;
        if (int'(f) == DEPTH) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end else begin
          k_d     = '0;
          wait_d  = '0;
          state_d = LOAD;
        end
      end

      LOAD: if (pool_1_en) begin
        if (wait_cnt == '0) begin
          conv_ena_d  = 1'b1;
          conv_addr_d = 15'(rd_addr);
          wait_d      = wait_cnt + WW'(1);
        end else if (int'(wait_cnt) < READ_WAIT) begin
          wait_d = wait_cnt + WW'(1);
        end else begin
          if (k == 2'd0 || $signed(bram.conv_result_bram_douta) > $signed(max_val))
            max_d = bram.conv_result_bram_douta;
          wait_d = '0;
          k_d    = k + 2'd1;
          if (k == 2'd3) begin
            conv_ena_d = 1'b0;
            state_d    = STORE;
          end
        end
      end

      STORE: if (pool_1_en) begin
        pool_ena_d  = 1'b1;
        pool_wea_d  = 1'b1;
        pool_addr_d = 12'(wr_addr);
        pool_dina_d = max_val;
        if (int'(c) == OUT_SIZE - 1) begin
          c_d = '0;
          if (int'(r) == OUT_SIZE - 1) begin
            r_d = '0;
            f_d = f + FW'(1);
          end else begin
            r_d = r + PW'(1);
          end
        end else begin
          c_d = c + PW'(1);
        end
        state_d = CHECK;
      end

      DONE: if (!pool_1_en) begin
        finish_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        conv_ena_d = 1'b0;
        pool_ena_d = 1'b0;
        pool_wea_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and clears every register, including
    // the output address/data registers, so the BRAM ports idle at zero.
    if (rst) begin
      state     <= IDLE;
      f         <= '0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      wait_cnt  <= '0;
      max_val   <= '0;
      conv_ena  <= 1'b0;
      conv_addr <= '0;
      pool_ena  <= 1'b0;
      pool_wea  <= 1'b0;
      pool_addr <= '0;
      pool_dina <= '0;
      finish    <= 1'b0;
    end else begin
      state     <= state_d;
      f         <= f_d;
      r         <= r_d;
      c         <= c_d;
      k         <= k_d;
      wait_cnt  <= wait_d;
      max_val   <= max_d;
      conv_ena  <= conv_ena_d;
      conv_addr <= conv_addr_d;
      pool_ena  <= pool_ena_d;
      pool_wea  <= pool_wea_d;
      pool_addr <= pool_addr_d;
      pool_dina <= pool_dina_d;
      finish    <= finish_d;
    end
  end

  assign bram.conv_result_bram_ena   = conv_ena;
  assign bram.conv_result_bram_addra = conv_addr;
  assign bram.pool_result_bram_ena   = pool_ena;
  assign bram.pool_result_bram_wea   = pool_wea;
  assign bram.pool_result_bram_addra = pool_addr;
  assign bram.pool_result_bram_dina  = pool_dina;
  assign pool_1_finish               = finish;

endmodule

// File: tb/tb_pool_1.sv
// Scoreboard bench for pool_1: a BRAM model feeds the DUT, a pooling model
// queues expected writes, and a monitor checks data, address and timing.
module tb_pool_1;
  localparam int NIN     = 20 * 24 * 24;
  localparam int NOUT    = 20 * 12 * 12;
  localparam int PER_OUT = 18;
  localparam int FIRST   = 19;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pool_1_en;
  logic pool_1_finish;

  always #5 clk = ~clk;

  pool_1_if bus();

  pool_1 dut (
    .clk          (clk),
    .rst          (rst),
    .pool_1_en    (pool_1_en),
    .pool_1_finish(pool_1_finish),
    .bram         (bus)
  );

  logic [7:0] mem [NIN];
  logic [7:0] got_data [NOUT];
  int         hits [NOUT];
  exp_t       sb [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         nwr = 0;
  int         c0 = 0;
  int         extra = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Conv result BRAM: one-cycle registered read.
  always @(posedge clk)
    if (bus.conv_result_bram_ena)
      bus.conv_result_bram_douta <= (int'(bus.conv_result_bram_addra) < NIN)
                                    ? mem[bus.conv_result_bram_addra] : 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_max(input int f, input int r, input int c);
    int best = -129;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        int v = int'($signed(mem[f * 576 + (2 * r + dy) * 24 + 2 * c + dx]));
        if (v > best) best = v;
      end
    return 8'(best);
  endfunction

  task automatic push_model();
    for (int f = 0; f < 20; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++)
          sb.push_back('{addr: 12'(f * 144 + r * 12 + c), data: ref_max(f, r, c)});
  endtask

  task automatic set_win(input int c, input int e0, input int e1, input int e2, input int e3);
    mem[2 * c]      = 8'(e0);
    mem[2 * c + 1]  = 8'(e1);
    mem[24 + 2 * c] = 8'(e2);
    mem[25 + 2 * c] = 8'(e3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_conv_ena"},  32'(bus.conv_result_bram_ena), 0);
    check({tag, "_conv_addr"}, 32'(bus.conv_result_bram_addra), 0);
    check({tag, "_pool_ena"},  32'(bus.pool_result_bram_ena), 0);
    check({tag, "_pool_wea"},  32'(bus.pool_result_bram_wea), 0);
    check({tag, "_pool_addr"}, 32'(bus.pool_result_bram_addra), 0);
    check({tag, "_pool_dina"}, 32'(bus.pool_result_bram_dina), 0);
    check({tag, "_finish"},    32'(pool_1_finish), 0);
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int t = 0;
    while (nwr < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(nwr >= n), 1);
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pool_result_bram_wea) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(bus.pool_result_bram_addra), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(bus.pool_result_bram_addra), 32'(e.addr));
          check("wr_data", 32'(bus.pool_result_bram_dina), 32'(e.data));
        end
        check("wr_ena", 32'(bus.pool_result_bram_ena), 1);
        check("rd_ena_low_at_write", 32'(bus.conv_result_bram_ena), 0);
        check("wr_cycle", 32'(cyc - c0), 32'(FIRST + PER_OUT * nwr + extra));
        if (int'(bus.pool_result_bram_addra) < NOUT) begin
          got_data[bus.pool_result_bram_addra] = bus.pool_result_bram_dina;
          hits[bus.pool_result_bram_addra]++;
        end
        nwr++;
      end
    end
  end

  initial begin
    logic        held_ena;
    logic [14:0] held_addr;
    int          bad;

    bus.conv_result_bram_douta = 8'h00;
    rst       = 1'b1;
    pool_1_en = 1'b0;
    for (int i = 0; i < NIN; i++) mem[i] = 8'(i % 128);
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Run A: ramp data, a 10-cycle pause mid-LOAD, reset after output 500.
    push_model();
    nwr = 0; extra = 0; c0 = cyc;
    rst = 1'b0; pool_1_en = 1'b1;
    wait_writes(4, 200, "run_a_first_writes");
    repeat (5) @(negedge clk);
    pool_1_en = 1'b0;
    extra     = 10;
    held_ena  = bus.conv_result_bram_ena;
    held_addr = bus.conv_result_bram_addra;
    check("pause_rd_ena_high", 32'(held_ena), 1);
    repeat (10) begin
      @(negedge clk);
      check("pause_rd_ena", 32'(bus.conv_result_bram_ena), 32'(held_ena));
      check("pause_rd_addr", 32'(bus.conv_result_bram_addra), 32'(held_addr));
    end
    pool_1_en = 1'b1;
    wait_writes(500, 500 * PER_OUT + 100, "run_a_500_writes");
    check("ramp_out_0_0_0", 32'(got_data[0]), 25);
    check("ramp_out_0_11_11", 32'(got_data[143]), 63);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_run_reset");
    sb.delete();

    // Run B: random data with directed windows in map 0, row 0.
    for (int i = 0; i < NIN; i++) mem[i] = 8'($urandom);
    set_win(0, -5, -128, -1, -77);
    set_win(1, -128, -128, -128, -128);
    for (int p = 0; p < 4; p++)
      set_win(2 + p, (p == 0) ? 100 : 0, (p == 1) ? 100 : 0,
                     (p == 2) ? 100 : 0, (p == 3) ? 100 : 0);
    set_win(6, 50, 20, 50, -3);
    for (int i = 0; i < NOUT; i++) begin
      hits[i] = 0;
      got_data[i] = 8'h00;
    end
    push_model();
    nwr = 0; extra = 0; c0 = cyc;
    rst = 1'b0; pool_1_en = 1'b1;
    while (!pool_1_finish && (cyc - c0) < 52100) @(negedge clk);
    check("finish_cycle", 32'(cyc - c0), 51842);
    check("write_count", 32'(nwr), NOUT);
    check("scoreboard_drained", 32'(sb.size()), 0);
    bad = 0;
    for (int i = 0; i < NOUT; i++) if (hits[i] != 1) bad++;
    check("addr_each_once", 32'(bad), 0);
    check("neg_window", 32'(got_data[0]), 32'h0FF);
    check("all_min_window", 32'(got_data[1]), 32'h080);
    for (int p = 0; p < 4; p++) check("single_100", 32'(got_data[2 + p]), 100);
    check("tie_window", 32'(got_data[6]), 50);
    repeat (5) begin
      @(negedge clk);
      check("finish_held", 32'(pool_1_finish), 1);
    end
    pool_1_en = 1'b0;
    @(negedge clk);
    check("finish_cleared", 32'(pool_1_finish), 0);

    // Fresh run after DONE: first writes must restart at address 0.
    push_model();
    nwr = 0; extra = 0; c0 = cyc;
    pool_1_en = 1'b1;
    wait_writes(2, 100, "restart_writes");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pool_1_en = 1'b0;
    sb.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
